// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC engine family.
// Holds the FSM state type, bit-reflection helpers and common CRC presets.
package crc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0]  CRC8_DVB_S2_POLY        = 8'hD5;
  localparam logic [7:0]  CRC8_DVB_S2_INIT        = 8'h00;
  localparam logic [7:0]  CRC8_DVB_S2_XOR_OUT     = 8'h00;

  localparam logic [15:0] CRC16_CCITT_FALSE_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_FALSE_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_FALSE_XOR_OUT = 16'h0000;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFF_FFFF;
  // Raw (non-reflected) register value left after a good frame plus its CRC.
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    r = {<<{b}};
    return r;
  endfunction

  // Reverses the low `width` bits of value; result is right-aligned.
  function automatic logic [31:0] reflect(input logic [31:0] value, input int unsigned width);
    logic [31:0] r;
    r = {<<{value}};
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/crc_update_comb.sv
// Combinational CRC update: folds one DATA_W-bit beat into a CRC_W-bit register.
// Bytes are taken most-significant first, bits MSB-first within each byte.
module crc_update_comb
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W  = 8,
  parameter int unsigned      DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_DVB_S2_POLY),
  parameter bit               REFIN  = 1'b0
) (
  input  logic [CRC_W-1:0]  seed,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  next_reg
);

  function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] s,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0]  r;
    logic [DATA_W-1:0] rest;
    logic [7:0]        b;
    logic              fb;
    r    = s;
    rest = d;
    for (int i = 0; i < int'(DATA_W / 8); i++) begin
      b = rest[DATA_W-1 -: 8];
      if (REFIN) b = reflect8(b);
      rest = rest << 8;
      for (int j = 0; j < 8; j++) begin
        fb = r[CRC_W-1] ^ b[7];
        r  = (r << 1) ^ (fb ? POLY : '0);
        b  = b << 1;
      end
    end
    return r;
  endfunction

  assign next_reg = crc_beat(seed, data);

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: one result per in_sop/in_last frame, valid/ready on both sides.
// out_match flags a raw register equal to RESIDUE, so the block serves TX and RX.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 8,
  parameter int unsigned      DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_DVB_S2_POLY),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_match
);

  state_t           state, state_nxt;
  logic [CRC_W-1:0] crc_reg, seed, next_reg, refl_reg;
  logic             accept, frame_end;

  // A pending result blocks input only while it is not being consumed.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && in_last;
  // Explicit or implicit frame start always seeds from INIT, dropping any partial CRC.
  assign seed      = (state == IDLE || in_sop) ? INIT : crc_reg;
  assign refl_reg  = {<<{next_reg}};

  crc_update_comb #(
    .CRC_W (CRC_W),
    .DATA_W(DATA_W),
    .POLY  (POLY),
    .REFIN (REFIN)
  ) u_update (
    .seed    (seed),
    .data    (in_data),
    .next_reg(next_reg)
  );

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = in_last ? IDLE : BUSY;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      crc_reg <= INIT;
    end else begin
      state <= state_nxt;
      if (accept) crc_reg <= in_last ? INIT : next_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_crc   <= '0;
      out_match <= 1'b0;
    end else if (frame_end) begin
      out_valid <= 1'b1;
      out_crc   <= (REFOUT ? refl_reg : next_reg) ^ XOR_OUT;
      out_match <= (next_reg == RESIDUE);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised streaming CRC engine; successor to the fixed 8-bit CRC generator.
- Configurable CRC width, polynomial, init, reflection and final XOR. Processes DATA_W bits per accepted beat.
- Frames are delimited by in_sop/in_last with valid/ready handshakes on both sides.
- Emits one result per frame with a residue-check flag, so the same block serves TX generation and RX checking in the packet datapath.

Parameters:
CRC_W, 8, CRC width in bits (8..32)
DATA_W, 8, input beat width; must be a multiple of 8
POLY, 8'hD5, generator polynomial without implicit top bit (CRC_W bits)
INIT, 0, register value loaded at frame start (CRC_W bits)
XOR_OUT, 0, value XORed into the final result (CRC_W bits)
REFIN, 0, 1 = bit-reverse each input byte before processing
REFOUT, 0, 1 = bit-reverse the whole CRC_W result before XOR_OUT
RESIDUE, 0, expected raw register value after a frame with appended CRC (check mode)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  engine can accept a beat
in_data  in  DATA_W  beat data; most significant byte processed first
in_sop  in  1  first beat of frame
in_last  in  1  last beat of frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_crc  out  CRC_W  final CRC = refout(reg) ^ XOR_OUT
out_match  out  1  raw register after last beat == RESIDUE

Behaviour:
- Reset (async, active-high): state IDLE, crc_reg = INIT, out_valid = 0, out_crc = 0, out_match = 0, in_ready = 1 once reset deasserts.
- Beat accepted on a rising clk when in_valid & in_ready.
- in_ready = !out_valid | out_ready. A new beat may be accepted in the same cycle a pending result is consumed.
- Per beat: seed = (state IDLE or in_sop) ? INIT : crc_reg.
  - Each byte is optionally reflected (REFIN); bytes are taken MSB-byte first.
  - Each bit is processed MSB-first: fb = reg[CRC_W-1] ^ bit; reg = (reg << 1) ^ (fb ? POLY : 0).
  - The full DATA_W update is combinational in one cycle.
- States:
  - IDLE -> BUSY on an accepted beat with !in_last.
  - IDLE -> IDLE on an accepted beat with in_last (single-beat frame).
  - BUSY -> IDLE on an accepted beat with in_last.
  - BUSY + in_sop restarts from INIT and silently discards the partial CRC.
  - A beat in IDLE without in_sop is treated as an implicit start.
- Result: a last beat accepted at edge N gives out_valid = 1 after edge N (1-cycle latency).
  - out_crc = (REFOUT ? reverse(next_reg) : next_reg) ^ XOR_OUT.
  - out_match = (next_reg == RESIDUE).
  - crc_reg returns to INIT.
- Backpressure: out_valid, out_crc and out_match hold stable while !out_ready. out_valid clears on out_valid & out_ready unless a new last beat is accepted in that same cycle, in which case the new result is loaded.
- in_valid without acceptance: no state change. in_data, in_sop and in_last are ignored when in_valid = 0.
- Reset mid-frame: the partial frame is discarded and any pending result is dropped.
- Width rule: all CRC arithmetic is CRC_W bits; shifts truncate the top bit.

Decomposition:
- Package crc_pkg: state enum (IDLE, BUSY), reflect8 function, generic reflect function, default-parameter constants for CRC-8/DVB-S2, CRC-16/CCITT-FALSE and CRC-32.
- Sub-module crc_update_comb: combinational (seed, data) -> next_reg for DATA_W bits, parametrised on CRC_W, DATA_W, POLY, REFIN. Reused by the later parallel/lane variants.

Test Plan:
- Defaults; single beat 0x01 with sop+last -> out_crc = 0xD5 one cycle later; beat 0x00 -> 0x00.
- Defaults; ASCII "123456789" as 9 beats (sop on the first, last on the ninth) -> out_crc = 0xBC; then "123456789",0xBC -> out_match = 1; "123456789",0xBD -> out_match = 0.
- CRC_W=16, POLY=16'h1021, INIT=16'hFFFF; "123456789" -> 0x29B1. CRC_W=32, POLY=32'h04C11DB7, INIT and XOR_OUT all-ones, REFIN=REFOUT=1 -> 0xCBF43926, also with DATA_W=32 (bytes packed MSB-first, 9 bytes padded as a final 8-bit frame run at DATA_W=8).
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_crc stable, in_ready=0; raise out_ready with next frame's last beat presented -> back-to-back results, no beat lost.
- Mid-frame in_sop after "1234", then "123456789" -> 0xBC (partial discarded); async reset asserted mid-frame -> out_valid=0 immediately, next frame result correct.
